// File: rtl/ascon_perm_sequencer.sv
// ASCON-128 permutation initiator: builds the init/final input state, starts the
// core, applies the key XOR to its result and returns it on a valid/ready handshake.
module ascon_perm_sequencer #(
   parameter logic [63:0] IV       = 64'h80400c0600000000,
   parameter int unsigned ROUNDS_A = 12,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         mode,
   input  logic [127:0] key,
   input  logic [127:0] nonce,
   input  logic [319:0] state_in,
   output logic [319:0] perm_S,
   output logic [4:0]   perm_round,
   output logic         perm_start,
   input  logic [319:0] perm_S_out,
   input  logic         perm_done,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [319:0] out_state,
   output logic [127:0] out_tag,
   output logic         err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [127:0]     key_q;
   logic             accept, done_hit, timeout_hit;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and control decode; a done in the timeout cycle takes priority
   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      done_hit    = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               accept  = 1'b1;
               state_d = S_START;
            end
         end
         S_START: state_d = S_WAIT;
         S_WAIT: begin
            if (perm_done) begin
               done_hit = 1'b1;
               state_d  = S_OUT;
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               timeout_hit = 1'b1;
               state_d     = S_IDLE;
            end
         end
         S_OUT: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake and pulse outputs follow the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready   <= 1'b0;
         perm_start <= 1'b0;
         out_valid  <= 1'b0;
         err        <= 1'b0;
      end else begin
         in_ready   <= (state_d == S_IDLE);
         perm_start <= accept;
         out_valid  <= (state_d == S_OUT);
         err        <= timeout_hit;
      end
   end

   // Counter holds cycles elapsed since perm_start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= '0;
      end else if (state_q == S_START || state_q == S_WAIT) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Request datapath: core input is held from START through WAIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q      <= '0;
         perm_S     <= '0;
         perm_round <= '0;
      end else if (accept) begin
         key_q      <= key;
         perm_round <= 5'(ROUNDS_A);
         if (mode) perm_S <= state_in ^ {64'b0, key, 128'b0};
         else      perm_S <= {IV, key, nonce};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           out_state <= '0;
      else if (done_hit) out_state <= perm_S_out ^ {192'b0, key_q};
   end

   assign out_tag = out_state[127:0];

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Bench for ascon_perm_sequencer: stub permutation core (~S, programmable done
// delay), word-level reference model, directed corner cases plus random requests.
module tb_ascon_perm_sequencer;

   localparam int unsigned    TIMEOUT = 64;
   localparam logic [63:0]    IV      = 64'h80400c0600000000;
   localparam logic [127:0]   ONES128 = {128{1'b1}};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         mode = 1'b0;
   logic [127:0] key = '0;
   logic [127:0] nonce = '0;
   logic [319:0] state_in = '0;
   logic [319:0] perm_S;
   logic [4:0]   perm_round;
   logic         perm_start;
   logic [319:0] perm_S_out;
   logic         perm_done;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [319:0] out_state;
   logic [127:0] out_tag;
   logic         err;

   ascon_perm_sequencer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .key(key), .nonce(nonce), .state_in(state_in),
      .perm_S(perm_S), .perm_round(perm_round), .perm_start(perm_start),
      .perm_S_out(perm_S_out), .perm_done(perm_done),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_state(out_state), .out_tag(out_tag), .err(err)
   );

   always #5 clk = ~clk;

   // Stub core: done pulses stub_delay cycles after the cycle perm_start is high
   logic stub_done = 1'b0;
   logic inj_done  = 1'b0;
   int   stub_cnt   = 0;
   bit   stub_armed = 1'b0;
   int   stub_delay = 7;
   bit   stub_never = 1'b0;

   assign perm_S_out = ~perm_S;
   assign perm_done  = stub_done | inj_done;

   always @(posedge clk) begin
      stub_done <= 1'b0;
      if (perm_start) begin
         stub_cnt   <= 1;
         stub_armed <= !stub_never;
      end else if (stub_armed) begin
         stub_cnt <= stub_cnt + 1;
         if (stub_cnt + 1 == stub_delay) begin
            stub_done  <= 1'b1;
            stub_armed <= 1'b0;
         end
      end
   end

   // Event counters for accepted requests, transferred results and error pulses
   int n_acc = 0, n_xfer = 0, n_err = 0;
   always @(posedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready)   n_acc  = n_acc + 1;
         if (out_valid && out_ready) n_xfer = n_xfer + 1;
         if (err)                    n_err  = n_err + 1;
      end
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model on 64-bit words x0..x4 (x0 most significant)
   function automatic logic [319:0] pack5(input logic [63:0] x[5]);
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

   function automatic logic [319:0] model_perm_in(input bit md, input logic [127:0] k,
                                                  input logic [127:0] n, input logic [319:0] st);
      logic [63:0] x[5];
      if (md) begin
         for (int i = 0; i < 5; i++) x[i] = st[319-64*i -: 64];
         x[1] = x[1] ^ k[127:64];
         x[2] = x[2] ^ k[63:0];
      end else begin
         x[0] = IV;
         x[1] = k[127:64];
         x[2] = k[63:0];
         x[3] = n[127:64];
         x[4] = n[63:0];
      end
      return pack5(x);
   endfunction

   function automatic logic [319:0] model_out(input logic [319:0] pin, input logic [127:0] k);
      logic [63:0] x[5];
      for (int i = 0; i < 5; i++) x[i] = ~pin[319-64*i -: 64];
      x[3] = x[3] ^ k[127:64];
      x[4] = x[4] ^ k[63:0];
      return pack5(x);
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic wait_ready(input string tg);
      int w = 0;
      while (!in_ready && w < 100) begin
         step();
         w++;
      end
      chk({tg, "_idle"}, 320'(in_ready), 320'd1);
   endtask

   // One full request; done arrives dly cycles after perm_start, consumer stalls hold cycles
   task automatic run_req(input bit md, input logic [127:0] k, input logic [127:0] n,
                          input logic [319:0] st, input int dly, input int hold,
                          input bit toggle_busy, input string tg);
      logic [319:0] exp_in, exp_out;
      int  acc0, xfer0, err0, c;
      bit  held_ok, hold_ok;
      exp_in  = model_perm_in(md, k, n, st);
      exp_out = model_out(exp_in, k);
      wait_ready(tg);
      acc0 = n_acc; xfer0 = n_xfer; err0 = n_err;
      stub_never = 1'b0;
      stub_delay = dly;
      mode = md; key = k; nonce = n; state_in = st; in_valid = 1'b1;
      step();
      in_valid = toggle_busy ? 1'($urandom) : 1'b0;
      chk({tg, "_start"}, 320'(perm_start), 320'd1);
      chk({tg, "_permS"}, perm_S, exp_in);
      chk({tg, "_round"}, 320'(perm_round), 320'd12);
      key = rand128(); nonce = rand128(); mode = ~md;
      step();
      chk({tg, "_start_once"}, 320'(perm_start), 320'd0);
      c = 2;
      held_ok = 1'b1;
      while (!out_valid && c < 200) begin
         if (perm_S !== exp_in || perm_round !== 5'd12 || in_ready) held_ok = 1'b0;
         if (toggle_busy) in_valid = 1'($urandom);
         step();
         c++;
      end
      in_valid = 1'b0;
      chk({tg, "_held"}, 320'(held_ok), 320'd1);
      chk({tg, "_lat"}, 320'(c), 320'(dly + 2));
      chk({tg, "_state"}, out_state, exp_out);
      chk({tg, "_tag"}, 320'(out_tag), 320'(exp_out[127:0]));
      hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         step();
         if (!out_valid || out_state !== exp_out || in_ready) hold_ok = 1'b0;
      end
      if (hold > 0) chk({tg, "_stall"}, 320'(hold_ok), 320'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tg, "_vdrop"}, 320'(out_valid), 320'd0);
      chk({tg, "_rdy_back"}, 320'(in_ready), 320'd1);
      chk({tg, "_n_acc"}, 320'(n_acc - acc0), 320'd1);
      chk({tg, "_n_xfer"}, 320'(n_xfer - xfer0), 320'd1);
      chk({tg, "_n_err"}, 320'(n_err - err0), 320'd0);
   endtask

   initial begin
      logic [319:0] st_before;
      int c, first_err, err_cnt;
      bit saw_valid, rdy_at_err;

      // Reset values while rst is held, then in_ready rises after release
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 320'(in_ready), 320'd0);
      chk("rst_out_state", out_state, 320'd0);
      chk("rst_perm_S", perm_S, 320'd0);
      rst = 1'b0;
      step();
      chk("post_rst_in_ready", 320'(in_ready), 320'd1);
      chk("post_rst_out_valid", 320'(out_valid), 320'd0);
      chk("post_rst_err", 320'(err), 320'd0);

      // Case 1: init, K = all ones, N = 0
      run_req(1'b0, ONES128, 128'd0, 320'd0, 7, 0, 1'b0, "t1");
      chk("t1_lit", out_state, {64'h7FBFF3F9FFFFFFFF, 256'h0});

      // Case 2: final, state_in = 0, K = all ones
      run_req(1'b1, ONES128, 128'd0, 320'd0, 7, 0, 1'b0, "t2");
      chk("t2_lit", out_state, {64'hFFFFFFFFFFFFFFFF, 256'h0});
      chk("t2_tag0", 320'(out_tag), 320'd0);

      // Case 3: consumer stalls 5 cycles
      run_req(1'b0, rand128(), rand128(), 320'd0, 7, 5, 1'b0, "t3");

      // Case 4: core never answers
      wait_ready("t4");
      st_before = out_state;
      stub_never = 1'b1;
      mode = 1'b0; key = rand128(); nonce = rand128(); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      c = 1; first_err = -1; err_cnt = 0; saw_valid = 1'b0; rdy_at_err = 1'b0;
      while (c < 80) begin
         step();
         c++;
         if (err) begin
            err_cnt++;
            if (first_err < 0) begin
               first_err  = c;
               rdy_at_err = in_ready;
            end
         end
         if (out_valid) saw_valid = 1'b1;
      end
      chk("t4_err_cycle", 320'(first_err), 320'(TIMEOUT + 2));
      chk("t4_err_count", 320'(err_cnt), 320'd1);
      chk("t4_ready", 320'(rdy_at_err), 320'd1);
      stub_never = 1'b0;
      inj_done = 1'b1;
      step();
      inj_done = 1'b0;
      repeat (3) begin
         step();
         if (out_valid) saw_valid = 1'b1;
      end
      chk("t4_no_valid", 320'(saw_valid), 320'd0);
      chk("t4_state_kept", out_state, st_before);
      chk("t4_ready_after", 320'(in_ready), 320'd1);

      // Case 5: asynchronous reset in the middle of WAIT; stale done follows
      wait_ready("t5");
      stub_delay = 7;
      mode = 1'b0; key = rand128(); nonce = rand128(); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      #2 rst = 1'b1;
      #1;
      chk("t5_in_ready", 320'(in_ready), 320'd0);
      chk("t5_perm_start", 320'(perm_start), 320'd0);
      chk("t5_perm_S", perm_S, 320'd0);
      chk("t5_perm_round", 320'(perm_round), 320'd0);
      chk("t5_out", {out_valid, err, out_state[317:0]}, 320'd0);
      chk("t5_tag", 320'(out_tag), 320'd0);
      step();
      rst = 1'b0;
      saw_valid = 1'b0;
      repeat (10) begin
         step();
         if (out_valid) saw_valid = 1'b1;
      end
      chk("t5_stale_done", 320'(saw_valid), 320'd0);
      run_req(1'b0, ONES128, 128'd0, 320'd0, 7, 0, 1'b0, "t5b");

      // Case 6: done exactly at the timeout limit with in_valid toggling while busy
      run_req(1'b0, rand128(), rand128(), 320'd0, TIMEOUT, 0, 1'b1, "t6");

      // Random requests
      for (int i = 0; i < 8; i++) begin
         run_req(1'($urandom), rand128(), rand128(), {rand128(), rand128(), 64'($urandom) << 32 | 64'($urandom)},
                 int'($urandom_range(2, 20)), int'($urandom_range(0, 3)), 1'($urandom), "rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
      $finish;
   end

endmodule
